// File: rtl/sdio_log_ctrl_pkg.sv
// rtl/sdio_log_ctrl_pkg.sv - shared constants, state encoding and checksum helper
package sdio_log_pkg;

    localparam int FRAME_LEN = 7;
    localparam int REC_W     = 40;

    localparam logic [2:0] IDX_SYNC = 3'd0;
    localparam logic [2:0] IDX_CMD  = 3'd1;
    localparam logic [2:0] IDX_A3   = 3'd2;
    localparam logic [2:0] IDX_A2   = 3'd3;
    localparam logic [2:0] IDX_A1   = 3'd4;
    localparam logic [2:0] IDX_A0   = 3'd5;
    localparam logic [2:0] IDX_CHK  = 3'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    // XOR of the command byte and the four argument bytes
    function automatic logic [7:0] rec_chk(input logic [REC_W-1:0] rec);
        return rec[39:32] ^ rec[31:24] ^ rec[23:16] ^ rec[15:8] ^ rec[7:0];
    endfunction

endpackage

// File: rtl/sdio_log_ctrl_if.sv
// rtl/sdio_log_ctrl_if.sv - capture input, byte stream output and status bundle
interface sdio_log_ctrl_if #(
    parameter int ADDR_W = 3
);
    logic            enable_i;
    logic            cap_done_i;
    logic [7:0]      cap_cmd_i;
    logic [31:0]     cap_arg_i;
    logic [7:0]      tx_data_o;
    logic            tx_valid_o;
    logic            tx_ready_i;
    logic [ADDR_W:0] fifo_level_o;
    logic [7:0]      drop_cnt_o;
    logic            busy_o;

    modport master (
        output enable_i, cap_done_i, cap_cmd_i, cap_arg_i, tx_ready_i,
        input  tx_data_o, tx_valid_o, fifo_level_o, drop_cnt_o, busy_o
    );

    modport slave (
        input  enable_i, cap_done_i, cap_cmd_i, cap_arg_i, tx_ready_i,
        output tx_data_o, tx_valid_o, fifo_level_o, drop_cnt_o, busy_o
    );
endinterface

// File: rtl/sdio_rec_fifo.sv
// rtl/sdio_rec_fifo.sv - single-clock record FIFO with registered level
module sdio_rec_fifo
    import sdio_log_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [REC_W-1:0] i_data,
    output logic [REC_W-1:0] o_data,
    output logic [ADDR_W:0]  o_level,
    output logic             o_full,
    output logic             o_empty
);
    logic [REC_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              w_wr;
    logic              w_rd;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == (ADDR_W + 1)'(DEPTH));
    assign w_rd    = i_pop & ~o_empty;
    // a full FIFO still takes a push when a slot is freed in the same cycle
    assign w_wr    = i_push & (~o_full | w_rd);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/sdio_log_ctrl.sv
// rtl/sdio_log_ctrl.sv - queues SDIO command captures and frames them onto a byte stream
module sdio_log_ctrl
    import sdio_log_pkg::*;
#(
    parameter int         DEPTH     = 8,
    parameter int         ADDR_W    = 3,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic           sd_clk,
    input  logic           rst,
    sdio_log_ctrl_if.slave bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_cap_q;
    logic [7:0]       r_cmd;
    logic [31:0]      r_arg;
    logic [7:0]       r_chk;
    logic [2:0]       r_idx;
    logic [7:0]       r_drop;
    logic             r_busy;
    logic             w_push;
    logic             w_pop;
    logic             w_accept;
    logic             w_full;
    logic             w_empty;
    logic [7:0]       w_tx_data;
    logic [REC_W-1:0] w_rec;
    logic [REC_W-1:0] w_head;
    logic [ADDR_W:0]  w_level;
    logic             w_cmd_unused;

    assign w_cmd_unused = ^bus.cap_cmd_i[7:6];
    assign w_push = bus.cap_done_i & ~r_cap_q & bus.enable_i;
    assign w_rec  = {2'b00, bus.cap_cmd_i[5:0], bus.cap_arg_i};

    sdio_rec_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (sd_clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_rec),
        .o_data  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_accept    = 1'b0;
        w_tx_data   = 8'h00;
        case (r_state)
            ST_IDLE: if (!w_empty) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                w_pop       = 1'b1;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                w_accept = bus.tx_ready_i;
                case (r_idx)
                    IDX_SYNC: w_tx_data = SYNC_BYTE;
                    IDX_CMD:  w_tx_data = r_cmd;
                    IDX_A3:   w_tx_data = r_arg[31:24];
                    IDX_A2:   w_tx_data = r_arg[23:16];
                    IDX_A1:   w_tx_data = r_arg[15:8];
                    IDX_A0:   w_tx_data = r_arg[7:0];
                    IDX_CHK:  w_tx_data = r_chk;
                    default:  w_tx_data = 8'h00;
                endcase
                if (w_accept && r_idx == IDX_CHK) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sd_clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cap_q <= 1'b0;
            r_cmd   <= '0;
            r_arg   <= '0;
            r_chk   <= '0;
            r_idx   <= '0;
            r_drop  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cap_q <= bus.cap_done_i;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_pop) begin
                r_cmd <= w_head[39:32];
                r_arg <= w_head[31:0];
                r_chk <= rec_chk(w_head);
                r_idx <= IDX_SYNC;
            end else if (w_accept && r_idx != IDX_CHK) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_push && w_full && !w_pop && r_drop != 8'hFF) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    assign bus.tx_data_o    = w_tx_data;
    assign bus.tx_valid_o   = (r_state == ST_SEND);
    assign bus.fifo_level_o = w_level;
    assign bus.drop_cnt_o   = r_drop;
    assign bus.busy_o       = r_busy;
endmodule

// File: tb/tb_sdio_log_ctrl.sv
// tb/tb_sdio_log_ctrl.sv - directed and randomized checks of sdio_log_ctrl against a frame-list model
module tb_sdio_log_ctrl;
    logic       sd_clk = 1'b0;
    logic       rst;
    int         total = 0;
    int         bad = 0;
    bit         rand_rdy = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 sd_clk = ~sd_clk;

    sdio_log_ctrl_if #(.ADDR_W(3)) bus ();

    sdio_log_ctrl #(
        .DEPTH     (8),
        .ADDR_W    (3),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .sd_clk (sd_clk),
        .rst    (rst),
        .bus    (bus)
    );

    // a byte offered with ready high at mid-cycle is taken at the next edge
    always @(negedge sd_clk) begin
        if (rst === 1'b0 && bus.tx_valid_o === 1'b1 && bus.tx_ready_i === 1'b1)
            got_q.push_back(bus.tx_data_o);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sd_clk);
        #1;
        if (rand_rdy) bus.tx_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_frame(input logic [7:0] cmd, input logic [31:0] arg);
        logic [7:0] c;
        logic [7:0] b [7];
        c    = {2'b00, cmd[5:0]};
        b[0] = 8'hA5;
        b[1] = c;
        b[2] = arg[31:24];
        b[3] = arg[23:16];
        b[4] = arg[15:8];
        b[5] = arg[7:0];
        b[6] = c ^ arg[31:24] ^ arg[23:16] ^ arg[15:8] ^ arg[7:0];
        foreach (b[i]) exp_q.push_back(b[i]);
    endtask

    task automatic pulse(input logic [7:0] cmd, input logic [31:0] arg, input int hold);
        bus.cap_cmd_i  = cmd;
        bus.cap_arg_i  = arg;
        bus.cap_done_i = 1'b1;
        repeat (hold) tick();
        bus.cap_done_i = 1'b0;
        tick();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((bus.busy_o !== 1'b0 || bus.fifo_level_o !== 4'd0) && n < 600) begin
            tick();
            n++;
        end
        check({tag, " drain"}, 32'(n < 600), 1);
    endtask

    task automatic compare(input string tag);
        check({tag, " bytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s byte%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int         peak;
        int         n;
        bit         en;
        logic [7:0] rc;
        logic [31:0] ra;

        rst            = 1'b1;
        bus.enable_i   = 1'b0;
        bus.cap_done_i = 1'b0;
        bus.cap_cmd_i  = '0;
        bus.cap_arg_i  = '0;
        bus.tx_ready_i = 1'b1;
        tick();
        tick();
        check("rst valid", bus.tx_valid_o, 0);
        check("rst data", bus.tx_data_o, 0);
        check("rst level", bus.fifo_level_o, 0);
        check("rst drop", bus.drop_cnt_o, 0);
        check("rst busy", bus.busy_o, 0);
        rst          = 1'b0;
        bus.enable_i = 1'b1;
        tick();

        // single capture, exact latency and back-to-back bytes
        bus.cap_cmd_i  = 8'h11;
        bus.cap_arg_i  = 32'h0000_0200;
        bus.cap_done_i = 1'b1;
        tick();
        check("t1 level E0", bus.fifo_level_o, 1);
        check("t1 valid E0", bus.tx_valid_o, 0);
        bus.cap_done_i = 1'b0;
        tick();
        check("t1 busy E1", bus.busy_o, 1);
        check("t1 valid E1", bus.tx_valid_o, 0);
        tick();
        add_frame(8'h11, 32'h0000_0200);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t1 valid b%0d", i), bus.tx_valid_o, 1);
            check($sformatf("t1 data b%0d", i), bus.tx_data_o, exp_q[i]);
            tick();
        end
        check("t1 valid end", bus.tx_valid_o, 0);
        check("t1 busy end", bus.busy_o, 0);
        compare("t1");

        // backpressure while arg[23:16] is on the bus
        pulse(8'h11, 32'h0000_0200, 1);
        repeat (4) tick();
        check("t2 taken before stall", got_q.size(), 3);
        bus.tx_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2 hold valid %0d", i), bus.tx_valid_o, 1);
            check($sformatf("t2 hold data %0d", i), bus.tx_data_o, 8'h00);
            tick();
        end
        bus.tx_ready_i = 1'b1;
        add_frame(8'h11, 32'h0000_0200);
        drain("t2");
        compare("t2");

        // level held high gives one record
        peak = 0;
        bus.cap_cmd_i  = 8'hC5;
        bus.cap_arg_i  = 32'hDEAD_BEEF;
        bus.cap_done_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 3) bus.cap_done_i = 1'b0;
            if (int'(bus.fifo_level_o) > peak) peak = int'(bus.fifo_level_o);
        end
        check("t3 peak level", peak, 1);
        add_frame(8'hC5, 32'hDEAD_BEEF);
        drain("t3");
        compare("t3");

        // overflow: one record in the frame registers, DEPTH queued, rest dropped
        bus.tx_ready_i = 1'b0;
        for (int i = 0; i < 11; i++) begin
            rc = 8'(8'h20 + i);
            ra = $urandom;
            pulse(rc, ra, 1);
            if (i < 9) add_frame(rc, ra);
        end
        tick();
        check("t4 drop", bus.drop_cnt_o, 2);
        check("t4 level", bus.fifo_level_o, 8);
        check("t4 valid", bus.tx_valid_o, 1);
        bus.tx_ready_i = 1'b1;
        drain("t4");
        compare("t4");

        rst = 1'b1;
        tick();
        check("t4 rst drop", bus.drop_cnt_o, 0);
        check("t4 rst level", bus.fifo_level_o, 0);
        rst = 1'b0;
        tick();

        // disabled captures are ignored and not counted
        bus.enable_i = 1'b0;
        for (int i = 0; i < 3; i++) pulse(8'h05, $urandom, 1);
        repeat (10) tick();
        check("t5 no bytes", got_q.size(), 0);
        check("t5 drop", bus.drop_cnt_o, 0);
        check("t5 level", bus.fifo_level_o, 0);
        bus.enable_i = 1'b1;
        pulse(8'h07, 32'hA1B2_C3D4, 1);
        add_frame(8'h07, 32'hA1B2_C3D4);
        drain("t5");
        compare("t5");

        // reset mid-frame abandons the frame
        pulse(8'h2A, 32'h1234_5678, 1);
        repeat (5) tick();
        check("t6 idx4 data", bus.tx_data_o, 8'h56);
        rst = 1'b1;
        tick();
        check("t6 rst valid", bus.tx_valid_o, 0);
        check("t6 rst data", bus.tx_data_o, 0);
        check("t6 rst busy", bus.busy_o, 0);
        check("t6 rst level", bus.fifo_level_o, 0);
        check("t6 rst drop", bus.drop_cnt_o, 0);
        rst = 1'b0;
        got_q.delete();
        repeat (12) tick();
        check("t6 no bytes", got_q.size(), 0);
        pulse(8'h33, 32'h0F1E_2D3C, 1);
        add_frame(8'h33, 32'h0F1E_2D3C);
        drain("t6");
        compare("t6");

        // randomized bursts with random ready and enable
        rand_rdy = 1'b1;
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                en = ($urandom_range(0, 3) != 0);
                rc = 8'($urandom);
                ra = $urandom;
                bus.enable_i = en;
                pulse(rc, ra, $urandom_range(1, 3));
                if (en) add_frame(rc, ra);
                repeat ($urandom_range(0, 2)) tick();
            end
            bus.enable_i = 1'($urandom_range(0, 1));
            drain($sformatf("rnd%0d", r));
            compare($sformatf("rnd%0d", r));
        end
        rand_rdy       = 1'b0;
        bus.tx_ready_i = 1'b1;
        check("rnd drop", bus.drop_cnt_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
